parity_serializer: RTL and testbench

Transmit-side counterpart of the serial parity checker. Accepts a parallel WIDTH-bit word through a load/ready handshake and shifts it out LSB-first on a single serial line, followed by one generated parity bit. A one-cycle done strobe closes each frame. The block sits between the parallel data source and the serial link that feeds the checker.

---
 rtl/parity_serializer.sv | 139 +++++++++++++
 tb/tb_parity_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_serializer.sv
// Purpose: parallel-to-serial framer; shifts a WIDTH-bit word out LSB-first, then one parity bit.
// Latency: first serial bit 1 cycle after accept; frame-to-frame spacing WIDTH+3 cycles.
// Backpressure: ready is high only in IDLE; a load while ready=0 is dropped, not queued.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (release synchronous to clk)
//   din    parallel word, sampled only on the accepting edge (load & ready)
//   load   frame request
//   ready  high only while idle
//   sout   serial data line (data bits, then parity)
//   svalid high while sout carries a frame bit
//   pflag  high in the parity-bit cycle
//   done   one-cycle pulse in the cycle after the parity bit
`timescale 1ns/1ps
module parity_serializer #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             svalid,
  output logic             pflag,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             par, par_nxt;
  logic             accept;

  // Next-value outputs; every output is a flop loaded from these.
  logic ready_d, sout_d, svalid_d, pflag_d, done_d;

  assign accept = (state == IDLE) && load;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      par   <= par_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    par_nxt   = par;
    case (state)
      IDLE: begin
        if (load) begin
          sreg_nxt  = din;
          par_nxt   = (^din) ^ ODD;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sreg_nxt = sreg >> 1;
        // Counter stops advancing once the last data bit has been sent.
        if (cnt == LAST) begin
          state_nxt = PARITY;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      PARITY:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.  sout in SHIFT is the bit about to sit in
  // sreg[0]: din[0] on accept, sreg[1] on each later shift.
  always_comb begin
    ready_d  = 1'b0;
    sout_d   = 1'b0;
    svalid_d = 1'b0;
    pflag_d  = 1'b0;
    done_d   = 1'b0;
    case (state_nxt)
      IDLE:   ready_d = 1'b1;
      SHIFT: begin
        sout_d   = accept ? din[0] : sreg[1];
        svalid_d = 1'b1;
      end
      PARITY: begin
        sout_d   = par_nxt;
        svalid_d = 1'b1;
        pflag_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready  <= 1'b1;
      sout   <= 1'b0;
      svalid <= 1'b0;
      pflag  <= 1'b0;
      done   <= 1'b0;
    end else begin
      ready  <= ready_d;
      sout   <= sout_d;
      svalid <= svalid_d;
      pflag  <= pflag_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_serializer.sv
`timescale 1ns/1ps
module tb_parity_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, din1;
  logic       load, load1;
  logic       ready, sout, svalid, pflag, done;
  logic       ready1, sout1, svalid1, pflag1, done1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_serializer #(.WIDTH(8), .ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready), .sout(sout), .svalid(svalid), .pflag(pflag), .done(done)
  );

  parity_serializer #(.WIDTH(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .din(din1), .load(load1),
    .ready(ready1), .sout(sout1), .svalid(svalid1), .pflag(pflag1), .done(done1)
  );

  // Expected {ready,sout,svalid,pflag,done} for cycle T0+phase of a frame.
  function automatic logic [4:0] exp_vec(input int phase, input logic [7:0] w, input logic p);
    logic [4:0] v;
    v = 5'b10000;
    if (phase >= 1 && phase <= 8) v = {1'b0, w[phase-1], 1'b1, 1'b0, 1'b0};
    else if (phase == 9)          v = {1'b0, p, 1'b1, 1'b1, 1'b0};
    else if (phase == 10)         v = 5'b00001;
    return v;
  endfunction

  task automatic test_reset();
    checks++;
    if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", {ready, sout, svalid, pflag, done}, 5'b10000);
    end
    checks++;
    if ({ready1, sout1, svalid1, pflag1, done1} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state_odd: got %b expected %b", {ready1, sout1, svalid1, pflag1, done1}, 5'b10000);
    end
  endtask

  // One frame on the even-parity DUT. glitch>0 pulses load with gd during cycle T0+glitch.
  // din is scrambled after the accepting edge to show it is not resampled.
  task automatic run_frame(input string name, input logic [7:0] d, input logic p,
                           input int glitch, input logic [7:0] gd);
    logic [4:0] e;
    @(negedge clk);
    din  = d;
    load = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      load = (k == glitch);
      din  = (k == glitch) ? gd : ~d;
      e = exp_vec(k, d, p);
      checks++;
      if ({ready, sout, svalid, pflag, done} !== e) begin
        failures++;
        $display("FAIL %s cycle T0+%0d: got %b expected %b", name, k, {ready, sout, svalid, pflag, done}, e);
      end
    end
    load = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
        failures++;
        $display("FAIL %s idle after frame: got %b expected %b", name, {ready, sout, svalid, pflag, done}, 5'b10000);
      end
    end
  endtask

  task automatic test_basic();
    run_frame("frame_a5", 8'hA5, 1'b0, 0, 8'h00);
    run_frame("frame_07", 8'h07, 1'b1, 0, 8'h00);
    run_frame("frame_00", 8'h00, 1'b0, 0, 8'h00);
  endtask

  task automatic test_odd();
    logic [4:0] e;
    @(negedge clk);
    din1  = 8'h07;
    load1 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      load1 = 1'b0;
      e = exp_vec(k, 8'h07, 1'b0);
      checks++;
      if ({ready1, sout1, svalid1, pflag1, done1} !== e) begin
        failures++;
        $display("FAIL odd_07 cycle T0+%0d: got %b expected %b", k, {ready1, sout1, svalid1, pflag1, done1}, e);
      end
    end
  endtask

  task automatic test_ignored_load();
    run_frame("ignored_load", 8'hA5, 1'b0, 3, 8'h3C);
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int ph;
    @(negedge clk);
    din  = 8'hFF;
    load = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1)  din  = 8'h01;
      if (k == 12) load = 1'b0;
      ph = (k <= 11) ? k : k - 11;
      e  = (k <= 11) ? exp_vec(ph, 8'hFF, 1'b0) : exp_vec(ph, 8'h01, 1'b1);
      checks++;
      if ({ready, sout, svalid, pflag, done} !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, {ready, sout, svalid, pflag, done}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
      failures++;
      $display("FAIL back_to_back idle: got %b expected %b", {ready, sout, svalid, pflag, done}, 5'b10000);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    din  = 8'hA5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);   // now in cycle T0+5
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_mid_async: got %b expected %b", {ready, sout, svalid, pflag, done}, 5'b10000);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
        failures++;
        $display("FAIL reset_mid_held: got %b expected %b", {ready, sout, svalid, pflag, done}, 5'b10000);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, sout, svalid, pflag, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_mid_release: got %b expected %b", {ready, sout, svalid, pflag, done}, 5'b10000);
    end
    run_frame("after_reset_81", 8'h81, 1'b0, 0, 8'h00);
  endtask

  // Receiver-side decode of the serial stream, as the checker would see it.
  task automatic test_loopback();
    logic [7:0] d, rx;
    logic       rxp, got_done;
    int         bi;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom);
      @(negedge clk);
      din  = d;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      rx = 8'h00; rxp = 1'b0; bi = 0; got_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (svalid && !pflag && bi < 8) begin
          rx[bi] = sout;
          bi++;
        end
        if (pflag) rxp = sout;
        if (done) begin
          got_done = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (got_done !== 1'b1) begin
        failures++;
        $display("FAIL loopback_done word %0d: got %b expected %b", n, got_done, 1'b1);
      end
      checks++;
      if (rx !== d) begin
        failures++;
        $display("FAIL loopback_data word %0d: got %h expected %h", n, rx, d);
      end
      checks++;
      if (rxp !== (^d)) begin
        failures++;
        $display("FAIL loopback_parity word %0d (din %h): got %b expected %b", n, d, rxp, ^d);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    din   = 8'h00;
    load1 = 1'b0;
    din1  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_odd();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
